// File: rtl/othello_pkg.sv
// Shared constants for the Othello display path: select encodings, requester count,
// board geometry, screen limits and the cell-plot arbiter state type.
package othello_pkg;

    localparam int NUM_REQ   = 3;
    localparam int BOARD_DIM = 8;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;

    localparam logic [1:0] SEL_EMPTY  = 2'd0;
    localparam logic [1:0] SEL_BLACK  = 2'd1;
    localparam logic [1:0] SEL_WHITE  = 2'd2;
    localparam logic [1:0] SEL_CURSOR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Requester index successor, wrapping modulo NUM_REQ.
    function automatic logic [1:0] next_index(input logic [1:0] i);
        return (i == 2'(NUM_REQ - 1)) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/cell_arb_pick.sv
// Pure winner selection for the cell-plot arbiter. CELL_PLOT_ARB_RR_EN selects
// round-robin starting after the last owner; otherwise the lowest index wins.
import othello_pkg::*;

module cell_arb_pick (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         idx,
    output logic               valid
);

`ifdef CELL_PLOT_ARB_RR_EN
    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        cand  = next_index(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
            cand = next_index(cand);
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = 2'(k);
            end
        end
    end
`endif

    assign grant = valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/cell_plot_arbiter.sv
// Grants one of three cell-draw requesters the shared pixel-plot path and sweeps
// its board cell one pixel per cycle. CELL_PLOT_ARB_RR_EN enables round-robin.
import othello_pkg::*;

module cell_plot_arbiter #(
    parameter int CELL_SIZE = 12,
    parameter int ORIGIN_X  = 32,
    parameter int ORIGIN_Y  = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] cell_x,
    input  logic [3*NUM_REQ-1:0] cell_y,
    input  logic [2*NUM_REQ-1:0] sel,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 plot,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [1:0]           select
);

    localparam int CW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam logic [CW-1:0] PIX_LAST = CW'(CELL_SIZE - 1);

    logic [2:0] cx_arr  [NUM_REQ];
    logic [2:0] cy_arr  [NUM_REQ];
    logic [1:0] sel_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign cx_arr[gi]  = cell_x[3*gi +: 3];
            assign cy_arr[gi]  = cell_y[3*gi +: 3];
            assign sel_arr[gi] = sel[2*gi +: 2];
        end
    endgenerate

    arb_state_t         state_reg;
    logic [1:0]         ptr_reg;
    logic [1:0]         owner_reg;
    logic [CW-1:0]      px_reg, py_reg;
    logic [CW-1:0]      px_next, py_next;
    logic [7:0]         base_x_reg, base_x_next;
    logic [6:0]         base_y_reg, base_y_next;
    logic [NUM_REQ-1:0] win_grant;
    logic [1:0]         win_idx;
    logic               win_valid;

    cell_arb_pick u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Top-left pixel of the winning requester's cell.
    assign base_x_next = 8'(ORIGIN_X) + 8'(cx_arr[win_idx]) * 8'(CELL_SIZE);
    assign base_y_next = 7'(ORIGIN_Y) + 7'(cy_arr[win_idx]) * 7'(CELL_SIZE);

    always_comb begin
        px_next = px_reg + CW'(1);
        py_next = py_reg;
        if (px_reg == PIX_LAST) begin
            px_next = '0;
            py_next = py_reg + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= 2'd2;
            owner_reg  <= 2'd0;
            px_reg     <= '0;
            py_reg     <= '0;
            base_x_reg <= '0;
            base_y_reg <= '0;
            ack        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            plot       <= 1'b0;
            x          <= '0;
            y          <= '0;
            select     <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_reg  <= ST_DRAW;
                        ptr_reg    <= win_idx;
                        owner_reg  <= win_idx;
                        ack        <= win_grant;
                        busy       <= 1'b1;
                        plot       <= 1'b1;
                        px_reg     <= '0;
                        py_reg     <= '0;
                        base_x_reg <= base_x_next;
                        base_y_reg <= base_y_next;
                        x          <= base_x_next;
                        y          <= base_y_next;
                        select     <= sel_arr[win_idx];
                    end
                end
                ST_DRAW: begin
                    if (px_reg == PIX_LAST && py_reg == PIX_LAST) begin
                        state_reg <= ST_DONE;
                        plot      <= 1'b0;
                        done      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_reg;
                    end else begin
                        px_reg <= px_next;
                        py_reg <= py_next;
                        x      <= base_x_reg + 8'(px_next);
                        y      <= base_y_reg + 7'(py_next);
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_plot_arbiter.sv
// Directed self-checking bench for cell_plot_arbiter (default geometry plus a
// CELL_SIZE=4 instance); expectations follow the build's CELL_PLOT_ARB_RR_EN setting.
module tb_cell_plot_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req   = '0;
    logic [8:0] cell_x = '0, cell_y = '0;
    logic [5:0] sel   = '0;
    logic [2:0] ack, done;
    logic       busy, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] select;

    logic [2:0] req4 = '0;
    logic [8:0] cell_x4 = '0, cell_y4 = '0;
    logic [5:0] sel4 = '0;
    logic [2:0] ack4, done4;
    logic       busy4, plot4;
    logic [7:0] x4;
    logic [6:0] y4;
    logic [1:0] select4;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    cell_plot_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .cell_x(cell_x), .cell_y(cell_y),
        .sel(sel), .ack(ack), .done(done), .busy(busy), .plot(plot),
        .x(x), .y(y), .select(select)
    );

    cell_plot_arbiter #(.CELL_SIZE(4), .ORIGIN_X(32), .ORIGIN_Y(12)) dut4 (
        .clock(clock), .reset(reset), .req(req4), .cell_x(cell_x4), .cell_y(cell_y4),
        .sel(sel4), .ack(ack4), .done(done4), .busy(busy4), .plot(plot4),
        .x(x4), .y(y4), .select(select4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cell(input int i, input int cx, input int cy, input int s);
        cell_x[i*3 +: 3] = 3'(cx);
        cell_y[i*3 +: 3] = 3'(cy);
        sel[i*2 +: 2]    = 2'(s);
    endtask

    task automatic wait_ack(output int waited);
        waited = 0;
        while (ack === 3'b000 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 400) check("ack_timeout", 1, 0);
    endtask

    // Called at the pixel-0 cycle; returns at the idle cycle after done.
    task automatic sweep(input int owner, input int bx, input int by, input int sl,
                         input int raise_at, input string tag);
        int errs = 0;
        int fx = 0, fy = 0, lx = 0, ly = 0;
        for (int p = 0; p < 144; p++) begin
            if (plot !== 1'b1 || x !== 8'(bx + p % 12) || y !== 7'(by + p / 12) ||
                select !== 2'(sl) || done !== 3'b000 || busy !== 1'b1) errs++;
            if (p > 0 && ack !== 3'b000) errs++;
            if (p == 0)   begin fx = int'(x); fy = int'(y); end
            if (p == 143) begin lx = int'(x); ly = int'(y); end
            if (p == raise_at) begin
                req[1] = 1'b1;
                set_cell(1, 4, 5, 3);
            end
            @(negedge clock);
        end
        check({tag, "_pixels"}, errs, 0);
        check({tag, "_first_x"}, fx, bx);
        check({tag, "_first_y"}, fy, by);
        check({tag, "_last_x"}, lx, bx + 11);
        check({tag, "_last_y"}, ly, by + 11);
        check({tag, "_done"}, done, 3'b001 << owner);
        check({tag, "_done_plot"}, plot, 0);
        check({tag, "_done_busy"}, busy, 1);
        $display("[TB] sweep %s owner=%0d first=(%0d,%0d) last=(%0d,%0d) errs=%0d",
                 tag, owner, fx, fy, lx, ly, errs);
        @(negedge clock);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int last_cyc;
        int errs4;
        logic [2:0] exp_g [4];

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_ack", ack, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_plot", plot, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_select", select, 0);

        // Single request, cell (0,0), black
        reset = 1'b0;
        set_cell(0, 0, 0, 1);
        req = 3'b001;
        wait_ack(w);
        check("single_latency", w, 1);
        check("single_ack", ack, 3'b001);
        check("single_busy", busy, 1);
        req = 3'b000;
        sweep(0, 32, 12, 1, -1, "single");

        // Corner cell (7,7), white, requester 1
        set_cell(1, 7, 7, 2);
        req = 3'b010;
        wait_ack(w);
        check("corner_ack", ack, 3'b010);
        req = 3'b000;
        sweep(1, 116, 96, 2, -1, "corner");

        // All three held continuously after reset
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        set_cell(0, 1, 2, 1);
        set_cell(1, 3, 4, 3);
        set_cell(2, 5, 6, 2);
        req = 3'b111;
`ifdef CELL_PLOT_ARB_RR_EN
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`else
        exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`endif
        last_cyc = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ack(w);
            $display("[TB] contend grant %0d ack=%b cycle=%0d", g, ack, cyc);
            check($sformatf("contend_ack%0d", g), ack, exp_g[g]);
            if (g > 0) check($sformatf("contend_gap%0d", g), cyc - last_cyc, 146);
            last_cyc = cyc;
            @(negedge clock);
        end
        req = 3'b000;
        w = 0;
        while (busy !== 1'b0 && w < 400) begin
            @(negedge clock);
            w++;
        end
        check("contend_drain", busy, 0);

        // Requester 1 raised mid-sweep of requester 0
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        set_cell(0, 2, 1, 1);
        req = 3'b001;
        wait_ack(w);
        check("mid_ack0", ack, 3'b001);
        req = 3'b000;
        sweep(0, 56, 24, 1, 20, "mid0");
        wait_ack(w);
        check("mid_ack1_latency", w, 1);
        check("mid_ack1", ack, 3'b010);
        set_cell(1, 0, 0, 0);
        req = 3'b000;
        sweep(1, 80, 72, 3, -1, "mid1");

        // Reset at pixel 50 of a sweep
        set_cell(2, 0, 0, 2);
        req = 3'b100;
        wait_ack(w);
        check("abort_ack", ack, 3'b100);
        req = 3'b000;
        repeat (50) @(negedge clock);
        check("abort_px50_x", x, 34);
        check("abort_px50_y", y, 16);
        reset = 1'b1;
        req = 3'b110;
        set_cell(1, 6, 0, 1);
        set_cell(2, 0, 6, 2);
        @(negedge clock);
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        wait_ack(w);
        check("abort_regrant_latency", w, 1);
        check("abort_regrant_ack", ack, 3'b010);
        req = 3'b000;
        sweep(1, 104, 12, 1, -1, "regrant");

        // CELL_SIZE=4 instance, cell (2,3)
        cell_x4 = 9'd2;
        cell_y4 = 9'd3;
        sel4    = 6'd1;
        req4    = 3'b001;
        @(negedge clock);
        check("cs4_ack", ack4, 3'b001);
        req4 = 3'b000;
        errs4 = 0;
        for (int p = 0; p < 16; p++) begin
            if (plot4 !== 1'b1 || x4 !== 8'(40 + p % 4) || y4 !== 7'(24 + p / 4)) errs4++;
            @(negedge clock);
        end
        $display("[TB] cs4 sweep errs=%0d", errs4);
        check("cs4_pixels", errs4, 0);
        check("cs4_end_plot", plot4, 0);
        check("cs4_done", done4, 3'b001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
